// File: rtl/synth_ctrl_pkg.sv
// Shared types and helpers for the synth control register bank.
//   commit_state_e : commit FSM states (IDLE / PENDING / APPLY)
//   CTRL_*         : bit positions inside the CTRL register
//   STATUS_*       : field offsets inside the STATUS register
//   byte_merge     : byte-lane merge of a write into an existing word
package synth_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } commit_state_e;

  localparam int unsigned CTRL_COMMIT_BIT    = 0;
  localparam int unsigned CTRL_IMM_BIT       = 1;

  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_CNT_LSB     = 8;

  // Widest register the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MERGE_W    = 128;
  localparam int unsigned MERGE_BE_W = MERGE_W / 8;

  // Replace each byte of old_v with the byte of new_v where its enable is set.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_v,
    input logic [MERGE_W-1:0]    new_v,
    input logic [MERGE_BE_W-1:0] byte_en
  );
    logic [MERGE_W-1:0] merged;
    merged = old_v;
    for (int unsigned b = 0; b < MERGE_BE_W; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/synth_ctrl_commit_fsm.sv
// Commit sequencer for the shadow/active register bank.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   commit_req_i     : accepted COMMIT write (IMMEDIATE already excluded)
//   tick_i           : audio sample strobe
//   apply_c_o        : combinational; copy shadow -> active on this edge
//   cfg_update_o     : one-cycle pulse while the freshly applied bank is visible
//   commit_pending_o : high while waiting for the sample tick
//   count_o          : number of completed commits (wraps)
module synth_ctrl_commit_fsm
  import synth_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             commit_req_i,
  input  logic             tick_i,
  output logic             apply_c_o,
  output logic             cfg_update_o,
  output logic             commit_pending_o,
  output logic [CNT_W-1:0] count_o
);

  commit_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cfg_update_q;
  logic             pending_q;

  // Next-state logic; the copy happens on the PENDING -> APPLY edge.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    apply_c_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req_i) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (tick_i) begin
          state_d   = ST_APPLY;
          apply_c_o = 1'b1;
          count_d   = count_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        state_d = commit_req_i ? ST_PENDING : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      cfg_update_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      cfg_update_q <= (state_d == ST_APPLY);
      pending_q    <= (state_d == ST_PENDING);
    end
  end

  assign cfg_update_o     = cfg_update_q;
  assign commit_pending_o = pending_q;
  assign count_o          = count_q;

endmodule

// File: rtl/synth_ctrl_regbank.sv
// Avalon-MM control register bank with shadow/active double buffering.
// Software stages writes into the shadow bank and commits; the active bank
// (CFG_FLAT) is updated atomically on the next SAMPLE_TICK.
//   CLK, RESET            : clock, synchronous active-high reset
//   AVL_*                 : Avalon-MM slave (word addressed, 1-cycle read latency)
//   SAMPLE_TICK           : audio sample strobe
//   CFG_FLAT              : active bank, register i at [i*DATA_W +: DATA_W]
//   CFG_UPDATE            : pulse on the cycle a commit becomes visible
//   COMMIT_PENDING        : commit waiting for SAMPLE_TICK
// Map: 0..N_REGS-1 shadow, N_REGS CTRL (b0 COMMIT, b1 IMMEDIATE),
//      N_REGS+1 STATUS (b0 pending, [8 +: CNT_W] commit count).
module synth_ctrl_regbank
  import synth_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REGS = 48,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic [DATA_W/8-1:0]      AVL_BYTE_EN,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic                     AVL_CS,
  input  logic [DATA_W-1:0]        AVL_WRITEDATA,
  output logic [DATA_W-1:0]        AVL_READDATA,
  output logic                     AVL_READDATAVALID,
  input  logic                     SAMPLE_TICK,
  output logic [N_REGS*DATA_W-1:0] CFG_FLAT,
  output logic                     CFG_UPDATE,
  output logic                     COMMIT_PENDING
);

  localparam int unsigned CTRL_ADDR   = N_REGS;
  localparam int unsigned STATUS_ADDR = N_REGS + 1;

  logic [DATA_W-1:0] shadow_q [N_REGS];
  logic [DATA_W-1:0] shadow_d [N_REGS];
  logic [DATA_W-1:0] active_q [N_REGS];
  logic [DATA_W-1:0] active_d [N_REGS];
  logic [DATA_W-1:0] merged_c [N_REGS];
  logic              imm_q, imm_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rdata_c;
  logic              rvalid_q, rvalid_d;

  logic              wr_c, rd_c;
  logic [N_REGS-1:0] hit_c;
  logic              ctrl_hit_c, status_hit_c;
  logic              commit_req_c;
  logic              apply_c;
  logic              pending_w;
  logic [CNT_W-1:0]  count_w;

  // Address decode and strobe qualification.
  always_comb begin
    wr_c         = AVL_WRITE & AVL_CS;
    rd_c         = AVL_READ & AVL_CS;
    ctrl_hit_c   = (AVL_ADDR == ADDR_W'(CTRL_ADDR));
    status_hit_c = (AVL_ADDR == ADDR_W'(STATUS_ADDR));
    for (int unsigned i = 0; i < N_REGS; i++) begin
      hit_c[i] = (AVL_ADDR == ADDR_W'(i));
    end
  end

  // Byte-lane merge of the write data into each shadow register.
  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) begin
      merged_c[i] = DATA_W'(byte_merge(MERGE_W'(shadow_q[i]),
                                       MERGE_W'(AVL_WRITEDATA),
                                       MERGE_BE_W'(AVL_BYTE_EN)));
    end
  end

  // Bank update: commit copies the pre-edge shadow; an immediate-mode write
  // to the same register in that cycle is the newer value and wins.
  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (apply_c) active_d[i] = shadow_q[i];
      if (wr_c && hit_c[i]) begin
        shadow_d[i] = merged_c[i];
        if (imm_q) active_d[i] = merged_c[i];
      end
    end
  end

  // CTRL: IMMEDIATE is stored; COMMIT is a strobe gated by the pre-write IMMEDIATE.
  always_comb begin
    imm_d        = imm_q;
    commit_req_c = 1'b0;
    if (wr_c && ctrl_hit_c && AVL_BYTE_EN[0]) begin
      imm_d        = AVL_WRITEDATA[CTRL_IMM_BIT];
      commit_req_c = AVL_WRITEDATA[CTRL_COMMIT_BIT] & ~imm_q;
    end
  end

  // Read mux sees pre-write state, so a colliding write is not visible.
  always_comb begin
    rdata_c = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (hit_c[i]) rdata_c = shadow_q[i];
    end
    if (ctrl_hit_c) rdata_c[CTRL_IMM_BIT] = imm_q;
    if (status_hit_c) begin
      rdata_c[STATUS_PENDING_BIT]          = pending_w;
      rdata_c[STATUS_CNT_LSB +: CNT_W]     = count_w;
    end
    rdata_d  = rd_c ? rdata_c : rdata_q;
    rvalid_d = rd_c;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      imm_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      imm_q    <= imm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  synth_ctrl_commit_fsm #(
    .CNT_W (CNT_W)
  ) u_commit_fsm (
    .clk_i            (CLK),
    .reset_i          (RESET),
    .commit_req_i     (commit_req_c),
    .tick_i           (SAMPLE_TICK),
    .apply_c_o        (apply_c),
    .cfg_update_o     (CFG_UPDATE),
    .commit_pending_o (pending_w),
    .count_o          (count_w)
  );

  for (genvar g = 0; g < N_REGS; g++) begin : g_flat
    assign CFG_FLAT[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = rvalid_q;
  assign COMMIT_PENDING    = pending_w;

endmodule

// File: tb/tb_synth_ctrl_regbank.sv
// Directed bench for synth_ctrl_regbank: reads are scored through a queue of
// expected values pushed at issue and popped when READDATAVALID returns.
module tb_synth_ctrl_regbank;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 48;
  localparam int unsigned AW = 6;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = DW / 8;
  localparam logic [AW-1:0] CTRL_A = 6'd48;
  localparam logic [AW-1:0] STAT_A = 6'd49;

  logic              CLK;
  logic              RESET;
  logic [AW-1:0]     AVL_ADDR;
  logic [BW-1:0]     AVL_BYTE_EN;
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic              AVL_CS;
  logic [DW-1:0]     AVL_WRITEDATA;
  logic [DW-1:0]     AVL_READDATA;
  logic              AVL_READDATAVALID;
  logic              SAMPLE_TICK;
  logic [NR*DW-1:0]  CFG_FLAT;
  logic              CFG_UPDATE;
  logic              COMMIT_PENDING;

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  synth_ctrl_regbank #(
    .DATA_W (DW),
    .N_REGS (NR),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .AVL_ADDR          (AVL_ADDR),
    .AVL_BYTE_EN       (AVL_BYTE_EN),
    .AVL_READ          (AVL_READ),
    .AVL_WRITE         (AVL_WRITE),
    .AVL_CS            (AVL_CS),
    .AVL_WRITEDATA     (AVL_WRITEDATA),
    .AVL_READDATA      (AVL_READDATA),
    .AVL_READDATAVALID (AVL_READDATAVALID),
    .SAMPLE_TICK       (SAMPLE_TICK),
    .CFG_FLAT          (CFG_FLAT),
    .CFG_UPDATE        (CFG_UPDATE),
    .COMMIT_PENDING    (COMMIT_PENDING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] act(input int i);
    return CFG_FLAT[i*DW +: DW];
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    AVL_READ  = 1'b0;
    AVL_WRITE = 1'b0;
    AVL_CS    = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    AVL_ADDR      = a;
    AVL_WRITEDATA = d;
    AVL_BYTE_EN   = be;
    AVL_WRITE     = 1'b1;
    AVL_CS        = 1'b1;
    cyc();
    bus_idle();
  endtask

  // Pop one scoreboard entry once READDATAVALID shows, within a short budget.
  task automatic wait_rsp();
    int n;
    logic [DW-1:0] e;
    string t;
    n = 0;
    while (!AVL_READDATAVALID && n < 4) begin
      cyc();
      n++;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (!AVL_READDATAVALID) chk({t, "_valid_timeout"}, DW'(AVL_READDATAVALID), DW'(1));
    else                    chk(t, AVL_READDATA, e);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string t);
    AVL_ADDR = a;
    AVL_READ = 1'b1;
    AVL_CS   = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(t);
    cyc();
    bus_idle();
    wait_rsp();
  endtask

  task automatic do_commit();
    wr(CTRL_A, 32'h1, 4'hF);
    SAMPLE_TICK = 1'b1;
    cyc();
    SAMPLE_TICK = 1'b0;
    cyc();
  endtask

  initial begin
    RESET         = 1'b1;
    AVL_ADDR      = '0;
    AVL_BYTE_EN   = '0;
    AVL_WRITEDATA = '0;
    SAMPLE_TICK   = 1'b0;
    bus_idle();
    cyc();
    cyc();
    chk("rst_rdata",   AVL_READDATA, 32'h0);
    chk("rst_rvalid",  DW'(AVL_READDATAVALID), 32'h0);
    chk("rst_update",  DW'(CFG_UPDATE), 32'h0);
    chk("rst_pending", DW'(COMMIT_PENDING), 32'h0);
    chk("rst_flat",    DW'(|CFG_FLAT), 32'h0);
    RESET = 1'b0;
    cyc();

    // Byte-enable write
    wr(6'd3, 32'hAABBCCDD, 4'b0101);
    chk("be_active_untouched", act(3), 32'h0);
    rd(6'd3, 32'h00BB00DD, "be_read");
    cyc();
    chk("rdata_hold", AVL_READDATA, 32'h00BB00DD);
    chk("rvalid_drop", DW'(AVL_READDATAVALID), 32'h0);

    // Read and write same address in one cycle returns the old value
    AVL_ADDR = 6'd3; AVL_WRITEDATA = 32'h11111111; AVL_BYTE_EN = 4'hF;
    AVL_WRITE = 1'b1; AVL_READ = 1'b1; AVL_CS = 1'b1;
    exp_q.push_back(32'h00BB00DD);
    tag_q.push_back("rw_collide");
    cyc();
    bus_idle();
    wait_rsp();
    rd(6'd3, 32'h11111111, "rw_after");

    // Atomic commit of regs 14..19
    for (int r = 14; r <= 19; r++) wr(AW'(r), DW'(r - 13), 4'hF);
    wr(CTRL_A, 32'h1, 4'hF);
    chk("cmt_pending", DW'(COMMIT_PENDING), 32'h1);
    cyc();
    chk("cmt_hold_r14", act(14), 32'h0);
    chk("cmt_no_update", DW'(CFG_UPDATE), 32'h0);
    rd(STAT_A, 32'h1, "cmt_status_pend");
    SAMPLE_TICK = 1'b1;
    cyc();
    SAMPLE_TICK = 1'b0;
    chk("cmt_update", DW'(CFG_UPDATE), 32'h1);
    for (int r = 14; r <= 19; r++) chk("cmt_active", act(r), DW'(r - 13));
    chk("cmt_pend_clr", DW'(COMMIT_PENDING), 32'h0);
    cyc();
    chk("cmt_update_1cyc", DW'(CFG_UPDATE), 32'h0);
    rd(STAT_A, 32'h100, "cmt_status");

    // Write colliding with the applying tick
    wr(CTRL_A, 32'h1, 4'hF);
    AVL_ADDR = 6'd2; AVL_WRITEDATA = 32'h55; AVL_BYTE_EN = 4'hF;
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; SAMPLE_TICK = 1'b1;
    cyc();
    bus_idle();
    SAMPLE_TICK = 1'b0;
    chk("col_update", DW'(CFG_UPDATE), 32'h1);
    chk("col_active_old", act(2), 32'h0);
    cyc();
    chk("col_idle", DW'(COMMIT_PENDING), 32'h0);
    rd(6'd2, 32'h55, "col_shadow");
    SAMPLE_TICK = 1'b1;
    cyc();
    SAMPLE_TICK = 1'b0;
    chk("idle_tick_no_update", DW'(CFG_UPDATE), 32'h0);
    chk("idle_tick_active", act(2), 32'h0);

    // Immediate mode
    wr(CTRL_A, 32'h2, 4'hF);
    wr(6'd5, 32'h1234, 4'hF);
    chk("imm_active", act(5), 32'h1234);
    wr(CTRL_A, 32'h3, 4'hF);
    chk("imm_no_pending", DW'(COMMIT_PENDING), 32'h0);
    rd(STAT_A, 32'h200, "imm_status");
    rd(CTRL_A, 32'h2, "imm_ctrl_read");
    wr(CTRL_A, 32'h0, 4'hF);

    // Counter wrap: count is 2 here
    for (int k = 0; k < 253; k++) do_commit();
    rd(STAT_A, 32'hFF00, "cnt_255");
    do_commit();
    rd(STAT_A, 32'h0, "cnt_wrap");

    // COMMIT during APPLY re-arms directly
    wr(CTRL_A, 32'h1, 4'hF);
    SAMPLE_TICK = 1'b1;
    cyc();
    SAMPLE_TICK = 1'b0;
    chk("rearm_apply", DW'(CFG_UPDATE), 32'h1);
    AVL_ADDR = CTRL_A; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
    AVL_WRITE = 1'b1; AVL_CS = 1'b1;
    cyc();
    bus_idle();
    chk("rearm_pending", DW'(COMMIT_PENDING), 32'h1);
    chk("rearm_update_clr", DW'(CFG_UPDATE), 32'h0);
    rd(STAT_A, 32'h101, "rearm_status");

    // Reset while PENDING
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("rstp_pending", DW'(COMMIT_PENDING), 32'h0);
    chk("rstp_flat", DW'(|CFG_FLAT), 32'h0);
    rd(STAT_A, 32'h0, "rstp_status");
    rd(6'd14, 32'h0, "rstp_shadow");
    SAMPLE_TICK = 1'b1;
    cyc();
    SAMPLE_TICK = 1'b0;
    chk("rstp_tick_update", DW'(CFG_UPDATE), 32'h0);
    cyc();
    chk("rstp_tick_update2", DW'(CFG_UPDATE), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/synth_ctrl_regbank.md
Name: synth_ctrl_regbank

Overview:
Parametrised Avalon-MM control register bank for the synth datapath. It generalises the flat control register file in three ways: byte-enable writes, a registered read path, and double-buffered (shadow/active) registers. Multi-register updates such as filter coefficients, ADSR settings or delay parameters are staged by software and applied atomically on an audio sample boundary. It sits between the Avalon fabric and the voice, filter and delay blocks, and drives their configuration through the active bank.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
N_REGS, 48, number of shadow/active configuration registers, at addresses 0..N_REGS-1.
ADDR_W, 6, Avalon word-address width; must satisfy 2**ADDR_W >= N_REGS+2.
CNT_W, 8, width of the commit counter reported in STATUS.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
AVL_ADDR  in  ADDR_W  word address
AVL_BYTE_EN  in  DATA_W/8  byte-lane write enables
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_CS  in  1  chip select
AVL_WRITEDATA  in  DATA_W  write data
AVL_READDATA  out  DATA_W  registered read data
AVL_READDATAVALID  out  1  high one cycle after an accepted read
SAMPLE_TICK  in  1  one-cycle audio sample strobe
CFG_FLAT  out  N_REGS*DATA_W  active bank; register i occupies bits [i*DATA_W +: DATA_W]
CFG_UPDATE  out  1  one-cycle pulse on the cycle the active bank changes from a commit
COMMIT_PENDING  out  1  high while a commit is waiting for SAMPLE_TICK

Behaviour:
- One clock domain: CLK. RESET is synchronous, active-high.
- Reset: shadow, active, CTRL and commit counter cleared to 0; FSM to IDLE; AVL_READDATA=0; AVL_READDATAVALID=0; CFG_UPDATE=0; COMMIT_PENDING=0. A reset during PENDING discards the pending commit.
- Address map:
  - 0..N_REGS-1: shadow registers, read/write.
  - N_REGS: CTRL. Bit0 COMMIT is write-1-to-act and reads 0. Bit1 IMMEDIATE is read/write.
  - N_REGS+1: STATUS, read-only. Bit0 = pending; bits[8 +: CNT_W] = commit count.
  - Other addresses: reads return 0; writes are ignored.
- Write: accepted when AVL_WRITE & AVL_CS. Each byte lane b is updated only where AVL_BYTE_EN[b]=1.
- IMMEDIATE=1: a shadow write also updates the active register on the same edge. COMMIT writes are ignored and the counter does not change.
- Read: accepted when AVL_READ & AVL_CS. AVL_READDATA and AVL_READDATAVALID are registered, so latency is 1 cycle. AVL_READDATA holds its last value when no read is accepted; it is never X.
  - A read and a write to the same address in the same cycle returns the pre-write value.
- Commit FSM states: IDLE, PENDING, APPLY.
  - IDLE -> PENDING on a CTRL write with bit0=1 and IMMEDIATE=0. The IMMEDIATE value used is the pre-write value if bit1 is written in the same cycle.
  - PENDING -> APPLY on SAMPLE_TICK. On that edge: active <= shadow (values before the edge), counter++ (wraps 2**CNT_W-1 -> 0).
  - APPLY: CFG_UPDATE=1 for exactly one cycle. Goes to PENDING if a COMMIT write occurs in this cycle, else IDLE.
  - COMMIT write during PENDING: stays PENDING; no extra count.
  - Shadow writes during PENDING are accepted; the last write before the applying edge wins. A write in the same cycle as the applying SAMPLE_TICK is not included in that commit.
  - SAMPLE_TICK in IDLE: no effect.
- COMMIT_PENDING = (state == PENDING); it is also STATUS bit0.
- Writes to STATUS never alter state.

Decomposition:
- Package synth_ctrl_pkg contains:
  - the state enum (IDLE/PENDING/APPLY);
  - CTRL bit indices (COMMIT=0, IMMEDIATE=1);
  - STATUS field offsets;
  - a byte-merge function (old, new, byte_en) -> merged.
- Sub-module synth_ctrl_commit_fsm holds the state register, counter and CFG_UPDATE/COMMIT_PENDING generation.
- The top level holds the register arrays and the Avalon decode.

Test Plan:
1. Byte-enable write: write 0xAABBCCDD to address 3 with BYTE_EN=4'b0101, starting from 0 -> read of address 3 returns 0x00BB00DD one cycle later with READDATAVALID=1.
2. Atomic commit: write regs 14..19 = 1..6, then write CTRL=0x1 -> CFG_FLAT unchanged and COMMIT_PENDING=1 until SAMPLE_TICK. On the tick edge, regs 14..19 = 1..6 together, CFG_UPDATE pulses 1 cycle, STATUS reads 0x100.
3. Write colliding with tick: in PENDING, write reg 2=0x55 in the same cycle as SAMPLE_TICK -> active reg 2 keeps its old value; shadow reg 2=0x55; state returns to IDLE.
4. Immediate mode: write CTRL=0x2, then reg 5=0x1234 -> active reg 5=0x1234 the next cycle. A following CTRL=0x3 write leaves the counter and COMMIT_PENDING unchanged.
5. Counter wrap and re-arm: perform 256 commits -> count field reads 0. A COMMIT written during APPLY -> state goes directly back to PENDING.
6. Reset mid-PENDING: assert RESET while PENDING -> COMMIT_PENDING=0, CFG_FLAT=0, STATUS=0. A later SAMPLE_TICK causes no CFG_UPDATE.
